// File: rtl/reflet_seven_segment_scan_pkg.sv
// Shared constants for the reflet seven-segment scan driver: register
// offsets, CTRL bit positions and the hex glyph table (active-high, bit0 = A).
package reflet_seven_segment_scan_pkg;

    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_BRIGHT   = 4'd1;
    localparam logic [3:0] REG_SCAN_DIV = 4'd2;
    localparam logic [3:0] REG_BLINK    = 4'd3;
    localparam logic [3:0] REG_DIGIT0   = 4'd4;

    localparam int CTRL_ON    = 0;
    localparam int CTRL_RAW   = 1;
    localparam int CTRL_LZB   = 2;
    localparam int CTRL_COLON = 3;

    // Index 15 first: entry n is the glyph for hex value n.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/reflet_seven_segment_glyph.sv
// Combinational nibble-to-segment decoder; output is active-high, bit0 = A.
module reflet_seven_segment_glyph
    import reflet_seven_segment_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/reflet_seven_segment_scan.sv
// N-digit multiplexed seven-segment driver with prescaler, PWM brightness,
// leading-zero blanking and raw mode. Optional blink: REFLET_SEVEN_SEGMENT_BLINK_EN.
module reflet_seven_segment_scan
    import reflet_seven_segment_scan_pkg::*;
#(
    parameter int                        base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF10,
    parameter int                        digits         = 4,
    parameter logic [7:0]                div_default    = 8'd15,
    parameter bit                        seg_active_low = 1,
    parameter bit                        sel_active_low = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      write_en,
    output logic [6:0]                segments,
    output logic [digits-1:0]         selection,
    output logic                      dot,
    output logic                      colon
);

    localparam int CUR_W = (digits > 1) ? $clog2(digits) : 1;
    localparam int NREG  = 4 + digits;

    logic [3:0]               ctrl;
    logic [3:0]               bright;
    logic [7:0]               scan_div;
    logic [digits-1:0][7:0]   digit_reg;

    logic [base_addr_size-1:0] offset;
    logic [3:0]                reg_idx;
    logic                      hit;

    assign offset  = addr - base_addr;
    assign reg_idx = offset[3:0];
    assign hit     = enable && (offset < base_addr_size'(NREG));

`ifdef REFLET_SEVEN_SEGMENT_BLINK_EN
    logic [digits-1:0] blink;
    logic [15:0]       frame_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl      <= '0;
            bright    <= '0;
            scan_div  <= div_default;
            digit_reg <= '0;
`ifdef REFLET_SEVEN_SEGMENT_BLINK_EN
            blink     <= '0;
`endif
        end else if (hit && write_en) begin
            if (reg_idx == REG_CTRL)     ctrl     <= data_in[3:0];
            if (reg_idx == REG_BRIGHT)   bright   <= data_in[3:0];
            if (reg_idx == REG_SCAN_DIV) scan_div <= data_in;
`ifdef REFLET_SEVEN_SEGMENT_BLINK_EN
            if (reg_idx == REG_BLINK)    blink    <= data_in[digits-1:0];
`endif
            for (int i = 0; i < digits; i++) begin
                if (reg_idx == REG_DIGIT0 + 4'(i)) digit_reg[i] <= data_in;
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (hit) begin
            case (reg_idx)
                REG_CTRL:     data_out = {4'b0, ctrl};
                REG_BRIGHT:   data_out = {4'b0, bright};
                REG_SCAN_DIV: data_out = scan_div;
                REG_BLINK: begin
`ifdef REFLET_SEVEN_SEGMENT_BLINK_EN
                    data_out[digits-1:0] = blink;
`else
                    data_out = '0;
`endif
                end
                default: begin
                    for (int i = 0; i < digits; i++) begin
                        if (reg_idx == REG_DIGIT0 + 4'(i)) data_out = digit_reg[i];
                    end
                end
            endcase
        end
    end

    // Timing chain: prescaler -> 16-step PWM phase -> digit index.
    logic [7:0]       div_cnt;
    logic [3:0]       phase;
    logic [CUR_W-1:0] cur;
    logic             tick;
    logic             slot_end;
    logic             cur_last;

    assign tick     = (div_cnt >= scan_div);
    assign slot_end = tick && (phase == 4'hF);
    assign cur_last = (cur == CUR_W'(digits - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            phase   <= '0;
            cur     <= '0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                phase   <= phase + 4'd1;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            if (slot_end) cur <= cur_last ? '0 : cur + CUR_W'(1);
        end
    end

`ifdef REFLET_SEVEN_SEGMENT_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset) frame_cnt <= '0;
        else if (slot_end && cur_last) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

    // A digit is blanked when it and every higher digit hold a zero nibble.
    logic [digits-1:0] blank_vec;
    logic              tail_zero;

    always_comb begin
        blank_vec = '0;
        tail_zero = 1'b1;
        for (int i = digits - 1; i >= 0; i--) begin
            tail_zero    = tail_zero && (digit_reg[i][3:0] == 4'h0);
            blank_vec[i] = tail_zero && (i != 0) && ctrl[CTRL_LZB] && !ctrl[CTRL_RAW];
        end
    end

    logic [7:0]        cur_byte;
    logic [6:0]        hex_seg;
    logic              blanked;
    logic              blink_off;
    logic              show;
    logic [6:0]        seg_l;
    logic [digits-1:0] sel_l;
    logic              dot_l;
    logic              colon_l;

    assign cur_byte = digit_reg[cur];
    assign blanked  = blank_vec[cur];

    reflet_seven_segment_glyph u_glyph (
        .nibble (cur_byte[3:0]),
        .seg    (hex_seg)
    );

`ifdef REFLET_SEVEN_SEGMENT_BLINK_EN
    assign blink_off = blink[cur] && frame_cnt[8];
`else
    assign blink_off = 1'b0;
`endif

    // A blanked digit keeps its select only to show a set dot.
    always_comb begin
        show    = ctrl[CTRL_ON] && (phase <= bright) && !blink_off && (!blanked || cur_byte[7]);
        seg_l   = '0;
        sel_l   = '0;
        dot_l   = 1'b0;
        colon_l = ctrl[CTRL_ON] && ctrl[CTRL_COLON];
        if (show) begin
            sel_l[cur] = 1'b1;
            dot_l      = cur_byte[7];
            if (!blanked) seg_l = ctrl[CTRL_RAW] ? cur_byte[6:0] : hex_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            segments  <= {7{seg_active_low}};
            selection <= {digits{sel_active_low}};
            dot       <= seg_active_low;
            colon     <= seg_active_low;
        end else begin
            segments  <= seg_l ^ {7{seg_active_low}};
            selection <= sel_l ^ {digits{sel_active_low}};
            dot       <= dot_l ^ seg_active_low;
            colon     <= colon_l ^ seg_active_low;
        end
    end

endmodule

// File: tb/tb_reflet_seven_segment_scan.sv
// Directed scoreboard bench for reflet_seven_segment_scan (4 digits, default polarity).
module tb_reflet_seven_segment_scan;

    localparam logic [15:0] BASE    = 16'hFF10;
    localparam logic [6:0]  SEG_OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        write_en = 1'b0;
    logic [6:0]  segments;
    logic [3:0]  selection;
    logic        dot;
    logic        colon;

    reflet_seven_segment_scan #(
        .base_addr_size (16),
        .base_addr      (BASE),
        .digits         (4),
        .div_default    (8'd15),
        .seg_active_low (1'b1),
        .sel_active_low (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .write_en  (write_en),
        .segments  (segments),
        .selection (selection),
        .dot       (dot),
        .colon     (colon)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         is_read;
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dot;
        logic       colon;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int failed = 0;

    // Pin-level glyphs for 1,2,3,4 (active-low segments).
    logic [6:0] gl [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests++;
            if (e.cyc < cyc) begin
                failed++;
                $display("FAIL %s: expectation for cycle %0d not checked until %0d", e.name, e.cyc, cyc);
            end else if (e.is_read) begin
                if (data_out !== e.data) begin
                    failed++;
                    $display("FAIL %s: data_out got %h want %h (cycle %0d)", e.name, data_out, e.data, cyc);
                end
            end else if ({selection, segments, dot, colon} !== {e.sel, e.seg, e.dot, e.colon}) begin
                failed++;
                $display("FAIL %s: sel/seg/dot/colon got %b %b %b %b want %b %b %b %b (cycle %0d)",
                         e.name, selection, segments, dot, colon, e.sel, e.seg, e.dot, e.colon, cyc);
            end
        end
    end

    task automatic exp_pins(input int c, input logic [3:0] sel, input logic [6:0] seg,
                            input logic d, input logic col, input string name);
        exp_t x;
        x.cyc = c; x.is_read = 1'b0; x.sel = sel; x.seg = seg; x.dot = d; x.colon = col;
        x.data = '0; x.name = name;
        q.push_back(x);
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        @(posedge clk); #1;
        enable = 1'b1; write_en = 1'b1; addr = BASE + 16'(off); data_in = d;
        @(posedge clk); #1;
        enable = 1'b0; write_en = 1'b0;
    endtask

    task automatic rd(input logic en, input logic [15:0] a, input logic [7:0] want, input string name);
        exp_t x;
        @(posedge clk); #1;
        enable = en; addr = a;
        x.cyc = cyc; x.is_read = 1'b1; x.sel = '0; x.seg = '0; x.dot = 1'b0; x.colon = 1'b0;
        x.data = want; x.name = name;
        q.push_back(x);
        @(negedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            tests++; failed++;
            $display("FAIL %s: %0d expectations never checked", name, q.size());
            q.delete();
        end
    endtask

    // Returns the cycle at whose negedge selection first moves prev -> tgt.
    task automatic sync(input logic [3:0] prev, input logic [3:0] tgt, input int bound,
                        input string name, output int c0);
        logic [3:0] last;
        last = selection;
        c0 = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (selection == tgt && last == prev) begin
                c0 = cyc;
                break;
            end
            last = selection;
        end
        if (c0 < 0) begin
            tests++; failed++;
            $display("FAIL %s: selection never went %b -> %b within %0d cycles", name, prev, tgt, bound);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, k, d, slot, w, cd, cl;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        exp_pins(cyc, 4'b0000, SEG_OFF, 1'b1, 1'b1, "reset_pins");
        rd(1'b1, BASE + 16'd2, 8'h0F, "reset_scan_div");
        rd(1'b1, BASE + 16'd0, 8'h00, "reset_ctrl");
        reset = 1'b0;

        // 1: full-duty scan, 16 clocks per digit.
        wr(2, 8'd0); wr(1, 8'd15);
        wr(4, 8'd1); wr(5, 8'd2); wr(6, 8'd3); wr(7, 8'd4);
        wr(0, 8'h01);
        sync(4'b1000, 4'b0001, 200, "t1_sync", c0);
        if (c0 >= 0) begin
            for (int i = 1; i <= 64; i++) begin
                d = (i / 16) % 4;
                exp_pins(c0 + i, 4'b0001 << d, gl[d], 1'b1, 1'b1, "t1_scan");
            end
        end
        drain("t1_drain");
        wr(0, 8'h00);
        k = cyc;
        if (c0 >= 0) begin
            d = ((k - c0) / 16) % 4;
            exp_pins(k, 4'b0001 << d, gl[d], 1'b1, 1'b1, "t1_latency_old");
        end
        exp_pins(k + 1, 4'b0000, SEG_OFF, 1'b1, 1'b1, "t1_latency_off");
        drain("t1_lat_drain");

        // 2: BRIGHT=3, SCAN_DIV=1, colon on and not PWM-gated.
        wr(0, 8'h09); wr(2, 8'd1); wr(1, 8'd3);
        sync(4'b0000, 4'b0001, 400, "t2_sync", c0);
        if (c0 >= 0) begin
            for (int i = 1; i < 96; i++) begin
                slot = i / 32; w = i % 32;
                if (w < 8) exp_pins(c0 + i, 4'b0001 << slot, gl[slot], 1'b1, 1'b0, "t2_pwm_lit");
                else       exp_pins(c0 + i, 4'b0000, SEG_OFF, 1'b1, 1'b0, "t2_pwm_dark");
            end
        end
        drain("t2_drain");

        // 3: leading-zero blanking.
        wr(2, 8'd0); wr(1, 8'd15);
        wr(7, 8'h00); wr(6, 8'h00); wr(5, 8'h07); wr(4, 8'h00);
        wr(0, 8'h05);
        sync(4'b0000, 4'b0001, 200, "t3_sync", c0);
        if (c0 >= 0) begin
            for (int i = 1; i < 64; i++) begin
                slot = i / 16;
                if (slot == 0)      exp_pins(c0 + i, 4'b0001, 7'b1000000, 1'b1, 1'b1, "t3_lzb_d0");
                else if (slot == 1) exp_pins(c0 + i, 4'b0010, 7'b1111000, 1'b1, 1'b1, "t3_lzb_d1");
                else                exp_pins(c0 + i, 4'b0000, SEG_OFF, 1'b1, 1'b1, "t3_lzb_blank");
            end
        end
        drain("t3_drain");
        wr(5, 8'h00);
        sync(4'b0000, 4'b0001, 200, "t3b_sync", c0);
        if (c0 >= 0) begin
            for (int i = 1; i < 64; i++) begin
                if (i < 16) exp_pins(c0 + i, 4'b0001, 7'b1000000, 1'b1, 1'b1, "t3_allzero_d0");
                else        exp_pins(c0 + i, 4'b0000, SEG_OFF, 1'b1, 1'b1, "t3_allzero_blank");
            end
        end
        drain("t3b_drain");

        // 4: raw mode (DIGIT bits are lit states), register reads.
        wr(4, 8'h00); wr(5, 8'hAA); wr(1, 8'hFF); wr(0, 8'hF3);
        sync(4'b0001, 4'b0010, 200, "t4_sync", c0);
        if (c0 >= 0) begin
            for (int i = 1; i < 16; i++)
                exp_pins(c0 + i, 4'b0010, 7'b1010101, 1'b0, 1'b1, "t4_raw_d1");
            exp_pins(c0 + 16, 4'b0100, SEG_OFF, 1'b1, 1'b1, "t4_raw_d2");
        end
        drain("t4_drain");
        rd(1'b1, BASE + 16'd5, 8'hAA, "t4_rd_digit1");
        rd(1'b1, BASE + 16'd8, 8'h00, "t4_rd_past_end");
        rd(1'b1, BASE + 16'd0, 8'h03, "t4_rd_ctrl_mask");
        rd(1'b1, BASE + 16'd1, 8'h0F, "t4_rd_bright_mask");
        rd(1'b1, BASE + 16'd2, 8'h00, "t4_rd_scan_div");
        rd(1'b0, BASE + 16'd5, 8'h00, "t4_rd_disabled");
        rd(1'b1, BASE - 16'd1, 8'h00, "t4_rd_below_base");

        // 5: reset mid-scan while lit with colon on.
        wr(0, 8'h09);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        k = cyc;
        exp_pins(k + 1, 4'b0000, SEG_OFF, 1'b1, 1'b1, "t5_reset_pins");
        rd(1'b1, BASE + 16'd0, 8'h00, "t5_rd_ctrl");
        rd(1'b1, BASE + 16'd1, 8'h00, "t5_rd_bright");
        rd(1'b1, BASE + 16'd2, 8'h0F, "t5_rd_scan_div");
        rd(1'b1, BASE + 16'd5, 8'h00, "t5_rd_digit1");
        rd(1'b1, BASE + 16'd3, 8'h00, "t5_rd_blink");
        reset = 1'b0;

        // 6: blink.
`ifdef REFLET_SEVEN_SEGMENT_BLINK_EN
        wr(2, 8'd0); wr(1, 8'd15); wr(0, 8'h01); wr(3, 8'h02);
        rd(1'b1, BASE + 16'd3, 8'h02, "t6_rd_blink");
        sync(4'b0001, 4'b0010, 200, "t6_sync_lit", c0);
        if (c0 >= 0)
            for (int i = 1; i < 16; i++)
                exp_pins(c0 + i, 4'b0010, 7'b1000000, 1'b1, 1'b1, "t6_blink_lit");
        drain("t6a_drain");
        sync(4'b0001, 4'b0000, 20000, "t6_sync_dark", cd);
        if (cd >= 0) begin
            for (int i = 1; i < 16; i++)
                exp_pins(cd + i, 4'b0000, SEG_OFF, 1'b1, 1'b1, "t6_blink_dark");
            exp_pins(cd + 16, 4'b0100, 7'b1000000, 1'b1, 1'b1, "t6_blink_d2");
        end
        drain("t6b_drain");
        sync(4'b0001, 4'b0010, 20000, "t6_sync_relit", cl);
        if (cd >= 0 && cl >= 0) begin
            tests++;
            if (cl - cd != 16384) begin
                failed++;
                $display("FAIL t6_blink_period: dark-to-relit got %0d cycles want 16384", cl - cd);
            end
        end
`else
        wr(3, 8'hFF);
        rd(1'b1, BASE + 16'd3, 8'h00, "t6_rd_blink_absent");
`endif
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
